// File: rtl/tweet_rx.sv
// tweet_rx: oversampling serial receiver for the tweet board.
// Synchronises serialIn, validates the start bit at its centre, shifts in
// 8 data bits LSB-first, checks the stop bit and presents each good byte on
// a registered data bus with a one-cycle valid strobe and a backspace flag.
// Optional even-parity bit between bit 7 and stop: define TWEET_RX_PARITY_EN.
module tweet_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned HALF_BIT     = 2604
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       serialIn,
  output logic [7:0] data,
  output logic       valid,
  output logic       is_bs,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] BREAK  = 3'd4;
`ifdef TWEET_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif

  logic          sync1;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
`ifdef TWEET_RX_PARITY_EN
  logic          par_bit;
`endif

  assign busy = (state != IDLE);

  // Two-flop synchroniser; the line idles high so both flops reset to 1.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serialIn;
      rx_s  <= sync1;
    end
  end

  // Frame FSM: counter clears at each sample point and on state entry.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data       <= '0;
      valid      <= 1'b0;
      is_bs      <= 1'b0;
      frame_err  <= 1'b0;
`ifdef TWEET_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef TWEET_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
`ifdef TWEET_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef TWEET_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
`ifdef TWEET_RX_PARITY_EN
            else if (par_bit != ^shift) begin
              parity_err <= 1'b1;
              state      <= IDLE;
            end
`endif
            else begin
              valid <= 1'b1;
              data  <= shift;
              is_bs <= (shift == 8'h08);
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef TWEET_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tweet_rx.sv
// Directed testbench for tweet_rx with CLKS_PER_BIT=16, HALF_BIT=8.
module tb_tweet_rx;

  localparam int CPB  = 16;
  localparam int HALF = 8;
`ifdef TWEET_RX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif
  // Falling edge driven after posedge 0: 2 sync cycles, 1 IDLE detect,
  // HALF to start centre, (FLEN-1) bit times to stop sample; valid after that edge.
  localparam int EXP_LAT = 3 + HALF + (FLEN - 1) * CPB;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       serialIn = 1'b1;
  logic [7:0] data;
  logic       valid, is_bs, frame_err, parity_err, busy;

  int checks = 0;
  int failures = 0;

  int n_valid = 0, n_ferr = 0, n_perr = 0;
  int n_long = 0, n_overlap = 0;
  logic p_valid = 1'b0, p_ferr = 1'b0, p_perr = 1'b0;
  logic [7:0] vlog[$];

  tweet_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .sysclk(sysclk), .reset(reset), .serialIn(serialIn),
    .data(data), .valid(valid), .is_bs(is_bs),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 sysclk = ~sysclk;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge sysclk) begin
    if (!reset) begin
      if (valid) begin n_valid++; vlog.push_back(data); end
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
      if ((valid && p_valid) || (frame_err && p_ferr) || (parity_err && p_perr)) n_long++;
      if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) n_overlap++;
    end
    p_valid = valid; p_ferr = frame_err; p_perr = parity_err;
  end

  function automatic logic [11:0] mk(input logic [7:0] d, input logic stopb, input logic parb);
`ifdef TWEET_RX_PARITY_EN
    return {1'b1, stopb, parb, d, 1'b0};
`else
    return {1'b1, 1'b1, stopb, d, 1'b0} ^ {2'b00, 1'b0, 8'h00, 1'b0} | {parb & 1'b0, 11'h000};
`endif
  endfunction

  // Caller is aligned to posedge+1; returns aligned the same way.
  task automatic send(input logic [7:0] d, input logic stopb, input logic parb);
    logic [11:0] fr;
    fr = mk(d, stopb, parb);
    for (int j = 0; j < FLEN; j++) begin
      serialIn = fr[j];
      repeat (CPB) @(posedge sysclk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    serialIn = 1'b1;
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset;
    #3 reset = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (is_bs !== 1'b0) begin failures++; $display("FAIL reset_is_bs got=%b exp=0", is_bs); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(posedge sysclk); #1;
    reset = 1'b0;
    idle(5);
  endtask

  task automatic test_latency;
    logic [11:0] fr;
    int first, hi, v0, f0;
    fr = mk(8'h41, 1'b1, 1'b0);
    first = -1; hi = 0; v0 = n_valid; f0 = n_ferr;
    for (int k = 0; k < 200; k++) begin
      serialIn = (k / CPB < FLEN) ? fr[k / CPB] : 1'b1;
      @(posedge sysclk); #1;
      if (valid) begin
        hi++;
        if (first < 0) first = k + 1;
      end
    end
    checks++; if (first != EXP_LAT) begin failures++; $display("FAIL lat_valid_rise got=%0d exp=%0d", first, EXP_LAT); end
    checks++; if (hi != 1) begin failures++; $display("FAIL lat_valid_width got=%0d exp=1", hi); end
    checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL lat_valid_count got=%0d exp=1", n_valid - v0); end
    checks++; if (data !== 8'h41) begin failures++; $display("FAIL lat_data got=%h exp=41", data); end
    checks++; if (is_bs !== 1'b0) begin failures++; $display("FAIL lat_is_bs got=%b exp=0", is_bs); end
    checks++; if (n_ferr - f0 != 0) begin failures++; $display("FAIL lat_frame_err got=%0d exp=0", n_ferr - f0); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send(8'h55, 1'b0, 1'b0);
    serialIn = 1'b0;
    repeat (100) @(posedge sysclk);
    #1;
    idle(30);
    checks++; if (n_ferr - f0 != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - f0); end
    checks++; if (n_valid - v0 != 0) begin failures++; $display("FAIL ferr_no_valid got=%0d exp=0", n_valid - v0); end
    checks++; if (data !== 8'h41) begin failures++; $display("FAIL ferr_data_hold got=%h exp=41", data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy_after got=%b exp=0", busy); end
    v0 = n_valid;
    send(8'h42, 1'b1, ^8'h42);
    idle(20);
    checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL after_break_valid got=%0d exp=1", n_valid - v0); end
    checks++; if (data !== 8'h42) begin failures++; $display("FAIL after_break_data got=%h exp=42", data); end
  endtask

  task automatic test_backspace;
    send(8'h08, 1'b1, ^8'h08);
    idle(20);
    checks++; if (data !== 8'h08) begin failures++; $display("FAIL bs_data got=%h exp=08", data); end
    checks++; if (is_bs !== 1'b1) begin failures++; $display("FAIL bs_is_bs got=%b exp=1", is_bs); end
    send(8'h61, 1'b1, ^8'h61);
    idle(20);
    checks++; if (data !== 8'h61) begin failures++; $display("FAIL bs_next_data got=%h exp=61", data); end
    checks++; if (is_bs !== 1'b0) begin failures++; $display("FAIL bs_next_is_bs got=%b exp=0", is_bs); end
  endtask

  task automatic test_glitch;
    int nb, s0;
    nb = 0; s0 = n_valid + n_ferr + n_perr;
    for (int k = 0; k < 30; k++) begin
      serialIn = (k < 4) ? 1'b0 : 1'b1;
      @(posedge sysclk); #1;
      if (busy) nb++;
    end
    checks++; if (nb != HALF) begin failures++; $display("FAIL glitch_busy_cycles got=%0d exp=%0d", nb, HALF); end
    checks++; if (n_valid + n_ferr + n_perr - s0 != 0) begin failures++; $display("FAIL glitch_strobes got=%0d exp=0", n_valid + n_ferr + n_perr - s0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [11:0] fr;
    int s0, v0;
    fr = mk(8'h5A, 1'b1, 1'b0);
    s0 = n_valid + n_ferr + n_perr;
    for (int j = 0; j < 5; j++) begin
      serialIn = fr[j];
      repeat (CPB) @(posedge sysclk);
      #1;
    end
    serialIn = fr[5];
    repeat (HALF) @(posedge sysclk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0 || is_bs !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL midrst_strobes got=%b%b%b exp=000", valid, is_bs, frame_err);
    end
    serialIn = 1'b1;
    @(posedge sysclk); #1;
    @(posedge sysclk); #1;
    reset = 1'b0;
    idle(20);
    checks++; if (n_valid + n_ferr + n_perr - s0 != 0) begin failures++; $display("FAIL midrst_no_strobe got=%0d exp=0", n_valid + n_ferr + n_perr - s0); end
    v0 = n_valid;
    send(8'h7E, 1'b1, ^8'h7E);
    idle(20);
    checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL midrst_next_valid got=%0d exp=1", n_valid - v0); end
    checks++; if (data !== 8'h7E) begin failures++; $display("FAIL midrst_next_data got=%h exp=7e", data); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] g0, g1;
    vlog.delete();
    send(8'h31, 1'b1, ^8'h31);
    send(8'h32, 1'b1, ^8'h32);
    idle(20);
    g0 = (vlog.size() > 0) ? vlog[0] : 8'hxx;
    g1 = (vlog.size() > 1) ? vlog[1] : 8'hxx;
    checks++; if (vlog.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", vlog.size()); end
    checks++; if (g0 !== 8'h31) begin failures++; $display("FAIL b2b_first got=%h exp=31", g0); end
    checks++; if (g1 !== 8'h32) begin failures++; $display("FAIL b2b_second got=%h exp=32", g1); end
  endtask

`ifdef TWEET_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = n_valid; p0 = n_perr;
    send(8'h41, 1'b1, 1'b1);
    idle(20);
    checks++; if (n_perr - p0 != 1) begin failures++; $display("FAIL par_err_count got=%0d exp=1", n_perr - p0); end
    checks++; if (n_valid - v0 != 0) begin failures++; $display("FAIL par_no_valid got=%0d exp=0", n_valid - v0); end
    checks++; if (data !== 8'h32) begin failures++; $display("FAIL par_data_hold got=%h exp=32", data); end
  endtask
`endif

  task automatic test_strobe_rules;
    checks++; if (n_long != 0) begin failures++; $display("FAIL strobe_width got=%0d exp=0", n_long); end
    checks++; if (n_overlap != 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", n_overlap); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_frame_err;
    test_backspace;
    test_glitch;
    test_reset_mid;
    test_back_to_back;
`ifdef TWEET_RX_PARITY_EN
    test_parity;
`endif
    test_strobe_rules;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
